alu_operand_sequencer: RTL and testbench
========================================

// Module: alu_operand_sequencer
// PURPOSE
//  Front-end stage that feeds the 4-bit logic units (OR/AND/... bit-sliced arrays) in the calculator.
//  Captures operand A, operand B and opcode from board switches, one per press of a confirm key.
//  Drives A/B/OP to the logic units, then registers the muxed unit result RES for display.
//  The sequencing is a 5-state FSM, and RESULT_VALID marks when the stored result is valid.
// PARAMETERS
//  WIDTH            4   operand/result width in bits; must be >= 2 (OP is taken from SW[1:0])
//  SYNC_STAGES      2   flip-flop stages in the KEY_N synchronizer; must be >= 2
//  DEBOUNCE_CYCLES  16  required stable-key cycles; used only when DEBOUNCE_EN is defined
// PORTS
//  CLK           in   1      system clock
//  RST_N         in   1      asynchronous reset, active-low
//  SW            in   WIDTH  switch bank: operand value, or opcode on SW[1:0]
//  KEY_N         in   1      confirm push-button, active-low, asynchronous to CLK
//  CLR           in   1      synchronous abort/clear, active-high, already synchronous to CLK
//  RES           in   WIDTH  combinational result from the selected logic unit (a function of A, B, OP)
//  A             out  WIDTH  operand A to logic units
//  B             out  WIDTH  operand B to logic units
//  OP            out  2      unit select to the result mux
//  RESULT        out  WIDTH  registered result
//  RESULT_VALID  out  1      1 while RESULT holds the result of the current A/B/OP
//  STATE         out  3      current FSM state, for the LEDs
// BEHAVIOUR
//  Reset (RST_N=0, async): A=B=RESULT=0, OP=0, RESULT_VALID=0, STATE=LOAD_A, sync flops=1 (released).
//  Key path: KEY_N -> SYNC_STAGES flops -> optional debounce -> level k.
//   PRESS is a 1-cycle pulse on the 1->0 edge of k. A held key gives exactly one PRESS.
//   Pin-to-PRESS latency without debounce: SYNC_STAGES+1 cycles.
//  States (STATE encoding): LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4. Codes 5-7 -> LOAD_A.
//   LOAD_A : on PRESS, A<=SW, go to LOAD_B
//   LOAD_B : on PRESS, B<=SW, go to LOAD_OP
//   LOAD_OP: on PRESS, OP<=SW[1:0], go to EXEC
//   EXEC   : exactly 1 cycle, RES is sampled; RESULT<=RES, RESULT_VALID<=1, go to SHOW. PRESS is ignored.
//   SHOW   : hold all outputs. On PRESS: RESULT_VALID<=0, go to LOAD_A.
//            A/B/OP/RESULT are kept until overwritten.
//  Latency: PRESS in LOAD_OP at cycle t -> OP updated at edge t+1 -> RESULT/RESULT_VALID at edge t+2.
//  A, B and OP change only on their own load edge, so RES is stable throughout EXEC.
//  CLR (sync) overrides PRESS in every state. Next edge: state LOAD_A, A=B=OP=RESULT=0, RESULT_VALID=0.
//   The synchronizer and debounce state are not affected by CLR.
//  RST_N asserted mid-sequence: immediate return to reset values. No partial load survives.
//  No arithmetic; all registers are WIDTH bits wide, and OP is always 2 bits.
// CONFIGURATION
//  DEBOUNCE_EN defined: the synchronized key must hold a new level for DEBOUNCE_CYCLES consecutive cycles
//   before k follows it. The counter restarts on any bounce. Pin-to-PRESS = SYNC_STAGES+DEBOUNCE_CYCLES+1.
//   The counter is sized by $clog2(DEBOUNCE_CYCLES+1) and resets to 0. k resets to 1.
//  DEBOUNCE_EN undefined: k = synchronizer output. DEBOUNCE_CYCLES is unused and no counter is built.
// TESTING
//  1 Full op: SW=1010 press, SW=0101 press, SW=01 press, with RES=A|B model
//    -> A=1010, B=0101, OP=01; RESULT=1111 and RESULT_VALID=1 two cycles after the OP-load PRESS.
//  2 Held key: KEY_N low for 100 cycles in LOAD_A -> exactly one advance (STATE 0->1), A loaded once.
//  3 CLR and PRESS in the same cycle in LOAD_B (A=1100) -> STATE=0, A=0, B unchanged at 0, RESULT_VALID=0.
//  4 Reset mid-op: RST_N=0 while in SHOW with RESULT=0111
//    -> RESULT=0, RESULT_VALID=0, STATE=0 with no clock edge needed.
//  5 SHOW press: after test 1, press -> STATE=0, RESULT_VALID=0, A=1010, B=0101 retained.
//  6 DEBOUNCE_EN, DEBOUNCE_CYCLES=16: a 10-cycle low glitch -> no advance.
//    A 20-cycle low -> one advance, PRESS 19 cycles after the pin edge (SYNC_STAGES=2).

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Operand/opcode capture sequencer for the 4-bit logic-unit calculator: LOAD_A -> LOAD_B -> LOAD_OP -> EXEC -> SHOW.
// Optional key debounce is compiled in when the DEBOUNCE_EN macro is defined.
module alu_operand_sequencer #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] SW,
  input  logic             KEY_N,
  input  logic             CLR,
  input  logic [WIDTH-1:0] RES,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [1:0]       OP,
  output logic [WIDTH-1:0] RESULT,
  output logic             RESULT_VALID,
  output logic [2:0]       STATE
);

  generate
    if (WIDTH < 2 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
      $error("alu_operand_sequencer: illegal parameter value");
    end
  endgenerate

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [1:0]       op_q;
  logic             valid_q;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_key;
  logic                   key_lvl;
  logic                   k_prev_q;
  logic                   press;

  // Synchronizer resets to the released (high) level so reset never looks like a press.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], KEY_N};
    end
  end

  assign sync_key = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             k_q;
  logic [CNT_W-1:0] cnt_q;

  // k only follows the synchronized key after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      k_q   <= 1'b1;
      cnt_q <= '0;
    end else if (sync_key == k_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      k_q   <= sync_key;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign key_lvl = k_q;
`else
  assign key_lvl = sync_key;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      k_prev_q <= 1'b1;
    end else begin
      k_prev_q <= key_lvl;
    end
  end

  assign press = k_prev_q & ~key_lvl;

  // CLR wins over PRESS in every state; RESULT_VALID stays high only while RESULT matches A/B/OP.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else if (CLR) begin
      state_q  <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (press) begin
            a_q     <= SW;
            state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (press) begin
            b_q     <= SW;
            state_q <= LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (press) begin
            op_q    <= SW[1:0];
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result_q <= RES;
          valid_q  <= 1'b1;
          state_q  <= SHOW;
        end
        SHOW: begin
          if (press) begin
            valid_q <= 1'b0;
            state_q <= LOAD_A;
          end
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

  assign A            = a_q;
  assign B            = b_q;
  assign OP           = op_q;
  assign RESULT       = result_q;
  assign RESULT_VALID = valid_q;
  assign STATE        = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed + randomized bench for alu_operand_sequencer with a result scoreboard.
// Covers the DEBOUNCE_EN build as well when that macro is defined.
module tb_alu_operand_sequencer;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 16;
`ifdef DEBOUNCE_EN
  localparam int KLAT = SYNC + DEB + 1;
`else
  localparam int KLAT = SYNC + 1;
`endif

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic [W-1:0] SW = '0;
  logic         KEY_N = 1'b1;
  logic         CLR = 1'b0;
  logic [W-1:0] RES;
  logic [W-1:0] A, B, RESULT;
  logic [1:0]   OP;
  logic         RESULT_VALID;
  logic [2:0]   STATE;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  alu_operand_sequencer #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .SW(SW), .KEY_N(KEY_N), .CLR(CLR), .RES(RES),
    .A(A), .B(B), .OP(OP), .RESULT(RESULT), .RESULT_VALID(RESULT_VALID), .STATE(STATE)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  // Logic-unit model: what the calculator's bit-sliced arrays compute.
  function automatic logic [W-1:0] unit_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  assign RES = unit_f(A, B, OP);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives SW and holds KEY_N low for 'hold' cycles; reports the cycle of the first
  // STATE change (0 if none) and of the RESULT_VALID rise, scoreboarding RESULT there.
  task automatic do_key(input logic [W-1:0] sw, input int hold, output int lat, output int rv_lat);
    logic [2:0] st0;
    logic       prev_rv;
    @(negedge CLK);
    st0     = STATE;
    prev_rv = RESULT_VALID;
    lat     = 0;
    rv_lat  = 0;
    SW      = sw;
    KEY_N   = 1'b0;
    for (int c = 1; c <= hold + KLAT + 4; c++) begin
      @(negedge CLK);
      if (c == hold) KEY_N = 1'b1;
      if (lat == 0 && STATE != st0) lat = c;
      if (RESULT_VALID && !prev_rv) begin
        rv_lat = c;
        if (exp_q.size() == 0) check("sb_unexpected_result", 32'd1, 32'd0);
        else check("sb_result", 32'(RESULT), 32'(exp_q.pop_front()));
      end
      prev_rv = RESULT_VALID;
    end
  endtask

  // One complete A/B/OP sequence with the expected result pushed at OP-load time.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    int lat, rv_lat;
    logic [W-1:0] opw;
    opw = '0;
    opw[1:0] = op;
    do_key(a, 5, lat, rv_lat);
    check("lat_a", 32'(lat), 32'(KLAT));
    check("a_loaded", 32'(A), 32'(a));
    do_key(b, 5, lat, rv_lat);
    check("b_loaded", 32'(B), 32'(b));
    check("state_op", 32'(STATE), 32'd2);
    exp_q.push_back(unit_f(a, b, op));
    do_key(opw, 5, lat, rv_lat);
    check("op_loaded", 32'(OP), 32'(op));
    check("rv_latency", 32'(rv_lat), 32'(lat + 1));
    check("state_show", 32'(STATE), 32'd4);
    check("rv_high", 32'(RESULT_VALID), 32'd1);
  endtask

  initial begin
    int lat, rv_lat;
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_state", 32'(STATE), 32'd0);
    check("rst_a", 32'(A), 32'd0);
    check("rst_b", 32'(B), 32'd0);
    check("rst_op", 32'(OP), 32'd0);
    check("rst_result", 32'(RESULT), 32'd0);
    check("rst_valid", 32'(RESULT_VALID), 32'd0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Full operation: 1010 | 0101 = 1111
    run_op(4'b1010, 4'b0101, 2'b01);
    check("full_result", 32'(RESULT), 32'hF);

    // Press in SHOW returns to LOAD_A, keeps operands
    do_key(4'b0000, 5, lat, rv_lat);
    check("show_state", 32'(STATE), 32'd0);
    check("show_valid", 32'(RESULT_VALID), 32'd0);
    check("show_keep_a", 32'(A), 32'hA);
    check("show_keep_b", 32'(B), 32'h5);
    check("show_keep_res", 32'(RESULT), 32'hF);

    // Held key: exactly one advance
    do_key(4'b0011, 100, lat, rv_lat);
    check("held_lat", 32'(lat), 32'(KLAT));
    check("held_state", 32'(STATE), 32'd1);
    check("held_a", 32'(A), 32'h3);

    // Plain CLR from LOAD_B
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    check("clr_state", 32'(STATE), 32'd0);
    check("clr_a", 32'(A), 32'd0);
    check("clr_op", 32'(OP), 32'd0);
    check("clr_result", 32'(RESULT), 32'd0);

    // CLR and PRESS on the same edge in LOAD_B
    do_key(4'b1100, 5, lat, rv_lat);
    check("t3_a", 32'(A), 32'hC);
    check("t3_state", 32'(STATE), 32'd1);
    SW = 4'b0110;
    KEY_N = 1'b0;
    repeat (KLAT - 1) @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    check("t3_clr_state", 32'(STATE), 32'd0);
    check("t3_clr_a", 32'(A), 32'd0);
    check("t3_clr_b", 32'(B), 32'd0);
    check("t3_clr_valid", 32'(RESULT_VALID), 32'd0);
    repeat (3) @(negedge CLK);
    KEY_N = 1'b1;
    repeat (KLAT + 4) @(negedge CLK);
    check("t3_no_late_press", 32'(STATE), 32'd0);

    // Randomized operations through the scoreboard
    for (int i = 0; i < 6; i++) begin
      ra  = W'($urandom_range(0, 15));
      rb  = W'($urandom_range(0, 15));
      rop = 2'($urandom_range(0, 3));
      run_op(ra, rb, rop);
      do_key(4'b0000, 5, lat, rv_lat);
      check("rand_back", 32'(STATE), 32'd0);
    end

    // Async reset mid-op while in SHOW with RESULT=0111
    run_op(4'b0101, 4'b0011, 2'b01);
    check("t4_result", 32'(RESULT), 32'h7);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("t4_rst_result", 32'(RESULT), 32'd0);
    check("t4_rst_valid", 32'(RESULT_VALID), 32'd0);
    check("t4_rst_state", 32'(STATE), 32'd0);
    check("t4_rst_a", 32'(A), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

`ifdef DEBOUNCE_EN
    do_key(4'b1001, 10, lat, rv_lat);
    check("glitch_no_adv", 32'(lat), 32'd0);
    check("glitch_state", 32'(STATE), 32'd0);
    do_key(4'b1001, 20, lat, rv_lat);
    check("deb_lat", 32'(lat), 32'(KLAT));
    check("deb_a", 32'(A), 32'h9);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
